// File: rtl/sp_inst_issuer.sv
// rtl/sp_inst_issuer.sv - fetches INST_NUM words from ROM, issues one per two cycles, then waits for retirement
// Optional DRAIN watchdog enabled by defining SP_ISSUE_TIMEOUT_EN.
module sp_inst_issuer #(
    parameter int INST_NUM = 16,
    parameter int TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] inst_addr,
    input  logic        out_valid,
    input  logic [31:0] rom_dout,
    output logic [11:0] rom_addr,
    output logic        in_valid,
    output logic [31:0] inst,
    output logic        busy,
    output logic        done,
    output logic [15:0] retired_cnt,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, FIN} state_t;

    localparam logic [15:0] NUM = 16'(INST_NUM);

    state_t      state, state_nxt;
    logic [15:0] issued_cnt;
    logic [31:0] inst_q;
    logic        active;
    logic        retire_ok;
    logic        retire_full;
    logic        timeout_hit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:14], inst_addr[1:0]};

    assign active      = (state == FETCH) || (state == ISSUE) || (state == DRAIN);
    assign retire_ok   = active && out_valid && (retired_cnt != NUM);
    // a retirement landing in this same cycle is enough to complete the drain
    assign retire_full = (retired_cnt == NUM) || (retire_ok && (retired_cnt + 16'd1 == NUM));

`ifdef SP_ISSUE_TIMEOUT_EN
    logic [31:0] drain_tmr;
    assign timeout_hit = (state == DRAIN) && !out_valid && (drain_tmr == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drain_tmr <= '0;
        else if (state != DRAIN || out_valid)
            drain_tmr <= '0;
        else
            drain_tmr <= drain_tmr + 32'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign in_valid = (state == ISSUE);
    assign inst     = in_valid ? rom_dout : inst_q;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: state_nxt = ISSUE;
            ISSUE: state_nxt = (issued_cnt + 16'd1 == NUM) ? DRAIN : FETCH;
            DRAIN: if (retire_full || timeout_hit) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            issued_cnt  <= '0;
            retired_cnt <= '0;
            err         <= 1'b0;
            rom_addr    <= '0;
            inst_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                issued_cnt  <= '0;
                retired_cnt <= '0;
                err         <= 1'b0;
            end
            if (state == FETCH)
                rom_addr <= inst_addr[13:2];
            if (state == ISSUE) begin
                issued_cnt <= issued_cnt + 16'd1;
                inst_q     <= rom_dout;
            end
            if (active && out_valid) begin
                if (retired_cnt == NUM)
                    err <= 1'b1;
                else
                    retired_cnt <= retired_cnt + 16'd1;
            end
            if (timeout_hit && !retire_full)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sp_inst_issuer.sv
// tb/tb_sp_inst_issuer.sv - randomized bench for sp_inst_issuer against a cycle-count reference model
module tb_sp_inst_issuer;

    localparam int N  = 4;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        out_valid = 1'b0;
    logic [31:0] rom_dout;
    logic [11:0] rom_addr;
    logic        in_valid;
    logic [31:0] inst;
    logic        busy;
    logic        done;
    logic [15:0] retired_cnt;
    logic        err;

    logic [31:0] rom [4096];
    int cyc = 0;
    int total = 0;
    int bad = 0;

    sp_inst_issuer #(.INST_NUM(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst_addr(inst_addr),
        .out_valid(out_valid), .rom_dout(rom_dout), .rom_addr(rom_addr),
        .in_valid(in_valid), .inst(inst), .busy(busy), .done(done),
        .retired_cnt(retired_cnt), .err(err)
    );

    assign rom_dout = rom[rom_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: retire only issued instructions, randomly; 1: retire every free cycle; 2: single retire
    // addr_kind 0: random, 1: word addresses 0,4,8,12, 2: first address 0x4008
    task automatic run(input int mode, input bit poke_start, input int addr_kind);
        logic [31:0] addr [N];
        logic [31:0] a;
        int k, strobes, t_n, rel, c0, exp_done, limit;
        bit seen_done, prev_iv, want;
        for (int i = 0; i < N; i++) begin
            addr[i] = $urandom & 32'hFFFF_FFFC;
            if (addr_kind == 1) addr[i] = 32'(4 * i);
        end
        if (addr_kind == 2) addr[0] = 32'h0000_4008;
        limit = (mode == 2) ? 60 : 200;
        inst_addr = addr[0];
        start = 1'b1;
        c0 = cyc;
        k = 0; strobes = 0; t_n = -1; seen_done = 0; prev_iv = 0;
        for (int s = 0; s < limit && !seen_done; s++) begin
            @(negedge clk);
            start = 1'b0;
            out_valid = 1'b0;
            rel = cyc - c0;
            if (poke_start && rel == 4) start = 1'b1;
            if (done) begin
                seen_done = 1;
`ifdef SP_ISSUE_TIMEOUT_EN
                exp_done = (mode == 2) ? 2 * N + 1 + TO : ((t_n + 1 > 2 * N + 2) ? t_n + 1 : 2 * N + 2);
`else
                exp_done = (t_n + 1 > 2 * N + 2) ? t_n + 1 : 2 * N + 2;
`endif
                check("done_cycle", 64'(rel), 64'(exp_done));
            end else if (in_valid) begin
                check("in_valid_gap", 64'(prev_iv), 64'd0);
                if (k < N) begin
                    a = addr[k];
                    check("inst", 64'(inst), 64'(rom[a[13:2]]));
                    check("rom_addr", 64'(rom_addr), 64'(a[13:2]));
                    check("issue_cycle", 64'(rel), 64'(2 + 2 * k));
                    if (addr_kind == 1) check("inst_const", 64'(inst), 64'(32'h1000_0000 + k));
                end
                k++;
                if (k < N) inst_addr = addr[k];
            end else begin
                case (mode)
                    0: want = (strobes < k) && ($urandom_range(1) == 1);
                    1: want = 1;
                    default: want = (strobes == 0);
                endcase
                if (want) begin
                    out_valid = 1'b1;
                    strobes++;
                    if (strobes == N) t_n = rel;
                end
            end
            prev_iv = in_valid;
        end
`ifndef SP_ISSUE_TIMEOUT_EN
        if (mode == 2) begin
            check("no_timeout_done", 64'(seen_done), 64'd0);
            check("no_timeout_busy", 64'(busy), 64'd1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
`endif
        if (!seen_done) check("done_seen", 64'(seen_done), 64'd1);
        @(negedge clk);
        out_valid = 1'b0;
        check("issued", 64'(k), 64'(N));
        check("done_pulse", 64'(done), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("retired", 64'(retired_cnt), 64'((strobes > N) ? N : strobes));
        check("err", 64'(err), 64'((mode == 2) || (strobes > N)));
        repeat (3) @(negedge clk);
        check("retired_hold", 64'(retired_cnt), 64'((strobes > N) ? N : strobes));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = $urandom;
        for (int i = 0; i < N; i++) rom[i] = 32'h1000_0000 + 32'(i);
        repeat (3) @(negedge clk);
        check("reset_outputs", {31'd0, in_valid, inst, rom_addr, busy, done, retired_cnt, err}, 64'd0);
        rst_n = 1'b1;
        run(0, 1'b0, 1);
        run(0, 1'b1, 2);
        run(1, 1'b0, 0);
        for (int r = 0; r < 6; r++) run(r % 2, r == 3, 0);

        // abort during the third issue
        inst_addr = $urandom & 32'hFFFF_FFFC;
        start = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b0;
        check("third_issue", 64'(in_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset", {31'd0, in_valid, inst, rom_addr, busy, done, retired_cnt, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 1'b0, 0);

        run(2, 1'b0, 0);
        run(0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
